// File: rtl/cpu_debug_sequencer_pkg.sv
// Shared types and constants for the CPU debug sequencer: FSM state encoding and the
// register-dump order table.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStep,
    StRun,
    StDumpSel,
    StDumpCap,
    StDumpOut
  } dbg_state_e;

  localparam int unsigned DUMP_LEN = 18;

  // Entry 0 sits in the least-significant slot: 16..23, 8..15, 24, 25.
  localparam logic [DUMP_LEN-1:0][4:0] DUMP_ORDER = {
    5'd25, 5'd24,
    5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9,  5'd8,
    5'd23, 5'd22, 5'd21, 5'd20, 5'd19, 5'd18, 5'd17, 5'd16
  };

  localparam logic [4:0] DUMP_LAST = 5'(DUMP_LEN - 1);

  function automatic logic [4:0] dump_order(input logic [4:0] i);
    return DUMP_ORDER[i];
  endfunction

endpackage

// File: rtl/cpu_debug_sequencer_if.sv
// Register-read port and dump output stream between the debug sequencer (master) and the
// CPU register file / dump consumer (slave).
interface cpu_debug_sequencer_if;
  logic [4:0]  switch_select;
  logic [31:0] reg_read_data_1;
  logic [31:0] dump_data;
  logic [4:0]  dump_idx;
  logic        dump_valid;
  logic        dump_ready;

  modport master (
    output switch_select,
    input  reg_read_data_1,
    output dump_data,
    output dump_idx,
    output dump_valid,
    input  dump_ready
  );

  modport slave (
    input  switch_select,
    output reg_read_data_1,
    input  dump_data,
    input  dump_idx,
    input  dump_valid,
    output dump_ready
  );
endinterface

// File: rtl/cpu_debug_sequencer_switch_debounce.sv
// Two-flop synchronizer plus counting debouncer for the raw run/step button; emits the
// filtered level and a one-cycle pulse on each accepted rising edge.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic switch_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= switch_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample that agrees with the accepted level restarts the stability count.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = sync2_q;
      rise_d  = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/cpu_debug_sequencer.sv
// Debug sequencer: single-step / continuous CPU advance and an 18-word register dump stream.
// Optional step counter enabled by defining DBG_STEP_COUNT_EN.
module cpu_debug_sequencer
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        fastclk,
  input  logic        reset,
  input  logic        switch_run,
  input  logic        run_mode,
  input  logic        dump_req,
  output logic        cpu_step_en,
  output logic        busy,
  output logic [15:0] step_count,
  cpu_debug_sequencer_if.master dbg_if
);

  dbg_state_e  state_q, state_d;
  logic        pending_q, pending_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  sel_q, sel_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  didx_q, didx_d;
  logic        step_en;
  logic        sw_level, sw_rise;

  switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_switch_debounce (
    .clk_i   (fastclk),
    .rst_i   (reset),
    .switch_i(switch_run),
    .level_o (sw_level),
    .rise_o  (sw_rise)
  );

  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      idx_q     <= 5'd0;
      sel_q     <= 5'd0;
      data_q    <= 32'd0;
      didx_q    <= 5'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      didx_q    <= didx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    data_d    = data_q;
    didx_d    = didx_q;
    step_en   = 1'b0;

    // A single flag: edges arriving while it is already set are simply absorbed.
    if (sw_rise && sw_level) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (dump_req) begin
          state_d = StDumpSel;
        end else if (pending_q && !run_mode) begin
          state_d = StStep;
        end else if (run_mode) begin
          state_d = StRun;
        end
      end
      StStep: begin
        step_en   = 1'b1;
        pending_d = 1'b0;
        state_d   = StIdle;
      end
      StRun: begin
        if (dump_req) begin
          state_d = StDumpSel;
        end else begin
          step_en = 1'b1;
          if (!run_mode) begin
            state_d = StIdle;
          end
        end
      end
      StDumpSel: begin
        state_d = StDumpCap;
      end
      StDumpCap: begin
        data_d  = dbg_if.reg_read_data_1;
        didx_d  = dump_order(idx_q);
        state_d = StDumpOut;
      end
      StDumpOut: begin
        if (dbg_if.dump_ready) begin
          if (idx_q == DUMP_LAST) begin
            idx_d   = 5'd0;
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = StDumpSel;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Select is launched on entry to DUMP_SEL so the read port settles for a full cycle.
    if (state_d == StDumpSel) begin
      sel_d = dump_order(idx_d);
    end
  end

  assign cpu_step_en          = step_en;
  assign busy                 = (state_q != StIdle);
  assign dbg_if.switch_select = sel_q;
  assign dbg_if.dump_data     = data_q;
  assign dbg_if.dump_idx      = didx_q;
  assign dbg_if.dump_valid    = (state_q == StDumpOut);

`ifdef DBG_STEP_COUNT_EN
  logic [15:0] step_cnt_q;

  always_ff @(posedge fastclk or posedge reset) begin
    if (reset) begin
      step_cnt_q <= 16'h0000;
    end else if (step_en) begin
      step_cnt_q <= step_cnt_q + 16'h0001;
    end
  end

  assign step_count = step_cnt_q;
`else
  assign step_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_debug_sequencer.sv
// Directed + randomized bench for cpu_debug_sequencer against a behavioural model of the
// dump order, handshake timing and step accounting.
module tb_cpu_debug_sequencer;

  logic        fastclk = 1'b0;
  logic        reset;
  logic        switch_run;
  logic        run_mode;
  logic        dump_req;
  logic        cpu_step_en;
  logic        busy;
  logic [15:0] step_count;

  cpu_debug_sequencer_if dbg();

  logic [31:0] mul_k  = 32'd1;
  logic [31:0] seed_k = 32'd0;

  int n_chk     = 0;
  int n_fail    = 0;
  int pulses    = 0;
  int cur_run   = 0;
  int max_run   = 0;
  int exp_steps = 0;

  function automatic logic [31:0] regfile(input logic [4:0] s);
    return ({27'h0, s} * mul_k) ^ seed_k;
  endfunction

  function automatic logic [4:0] exp_order(input int k);
    if (k < 8)       return 5'(16 + k);
    else if (k < 16) return 5'(k);
    else             return 5'(k + 8);
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef DBG_STEP_COUNT_EN
    return 16'(exp_steps);
`else
    return 16'h0000;
`endif
  endfunction

  assign dbg.reg_read_data_1 = regfile(dbg.switch_select);

  cpu_debug_sequencer #(
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .fastclk    (fastclk),
    .reset      (reset),
    .switch_run (switch_run),
    .run_mode   (run_mode),
    .dump_req   (dump_req),
    .cpu_step_en(cpu_step_en),
    .busy       (busy),
    .step_count (step_count),
    .dbg_if     (dbg)
  );

  always #5 fastclk = ~fastclk;

  always @(negedge fastclk) begin
    if (cpu_step_en === 1'b1) begin
      pulses  <= pulses + 1;
      cur_run <= cur_run + 1;
      if (cur_run + 1 > max_run) max_run <= cur_run + 1;
    end else begin
      cur_run <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge fastclk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_step_en"}, {31'd0, cpu_step_en}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid"}, {31'd0, dbg.dump_valid}, 32'd0);
    chk({tag, "_data"}, dbg.dump_data, 32'd0);
    chk({tag, "_idx"}, {27'd0, dbg.dump_idx}, 32'd0);
    chk({tag, "_sel"}, {27'd0, dbg.switch_select}, 32'd0);
    chk({tag, "_count"}, {16'd0, step_count}, 32'd0);
  endtask

  // mode 0: ready always high; 1: 10-cycle stall on register 20 plus a button press;
  // 2: random ready.
  task automatic run_dump(input int mode);
    int k = 0;
    int busy_cyc = 0;
    int stalls = 0;
    int cyc = 0;
    int p0 = pulses;
    bit done = 0;
    dbg.dump_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mode == 1) switch_run = 1'b1;
    dump_req = 1'b1;
    step(1);
    dump_req = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge fastclk);
      if (!busy) begin
        done = 1;
      end else begin
        busy_cyc++;
        if (dbg.dump_valid && dbg.dump_ready) begin
          chk($sformatf("dump%0d_idx_w%0d", mode, k), {27'd0, dbg.dump_idx},
              {27'd0, exp_order(k)});
          chk($sformatf("dump%0d_data_w%0d", mode, k), dbg.dump_data,
              regfile(exp_order(k)));
          k++;
        end else if (dbg.dump_valid) begin
          stalls++;
          if (mode == 1 && (stalls == 1 || stalls == 10))
            chk($sformatf("stall_data_%0d", stalls), dbg.dump_data, 32'h14);
        end
        step(1);
        cyc++;
        unique case (mode)
          1: begin
            dbg.dump_ready = !(k == 4 && stalls < 10);
            if (cyc == 30) switch_run = 1'b0;
          end
          2: dbg.dump_ready = 1'($urandom_range(0, 1));
          default: dbg.dump_ready = 1'b1;
        endcase
      end
    end
    chk($sformatf("dump%0d_timeout", mode), {31'd0, done}, 32'd1);
    chk($sformatf("dump%0d_words", mode), k, 18);
    chk($sformatf("dump%0d_busy_cycles", mode), busy_cyc, 54 + stalls);
    chk($sformatf("dump%0d_no_step", mode), pulses - p0, 0);
    dbg.dump_ready = 1'b1;
    if (mode == 1) begin
      chk("stall_len", stalls, 10);
      step(10);
      chk("collision_step", pulses - p0, 1);
      exp_steps += 1;
      chk("collision_count", {16'd0, step_count}, {16'd0, exp_cnt()});
    end
  endtask

  initial begin
    int p0;
    int n_wrap;
    reset = 1'b1;
    switch_run = 1'b0;
    run_mode = 1'b0;
    dump_req = 1'b0;
    dbg.dump_ready = 1'b1;
    #1;
    chk_reset_outputs("reset");
    step(3);
    reset = 1'b0;
    step(3);

    // Single step from a long press.
    p0 = pulses;
    switch_run = 1'b1;
    step(40);
    switch_run = 1'b0;
    step(30);
    chk("single_pulses", pulses - p0, 1);
    exp_steps += 1;
    chk("single_count", {16'd0, step_count}, {16'd0, exp_cnt()});

    // Bounce must never be accepted.
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      switch_run = ~switch_run;
      step(3);
    end
    switch_run = 1'b0;
    step(30);
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_busy", {31'd0, busy}, 32'd0);

    // Continuous run.
    p0 = pulses;
    run_mode = 1'b1;
    step(100);
    run_mode = 1'b0;
    step(5);
    chk("run_pulses", pulses - p0, 100);
    chk("run_consecutive", max_run, 100);
    exp_steps += 100;
    chk("run_count", {16'd0, step_count}, {16'd0, exp_cnt()});
    chk("run_idle", {31'd0, busy}, 32'd0);

    run_dump(0);
    step(2);
    run_dump(1);
    step(30);
    mul_k  = $urandom | 32'd1;
    seed_k = $urandom;
    run_dump(2);
    mul_k  = 32'd1;
    seed_k = 32'd0;
    step(2);

    // Reset in the middle of the sixth word.
    dump_req = 1'b1;
    step(1);
    dump_req = 1'b0;
    repeat (17) @(posedge fastclk);
    #2;
    chk("mid_valid", {31'd0, dbg.dump_valid}, 32'd1);
    chk("mid_idx", {27'd0, dbg.dump_idx}, 32'd21);
    reset = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    exp_steps = 0;
    step(3);
    reset = 1'b0;
    step(5);
    chk("post_reset_valid", {31'd0, dbg.dump_valid}, 32'd0);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    run_dump(0);

    // Long run across the counter wrap.
    p0 = pulses;
    n_wrap = 65539;
    run_mode = 1'b1;
    step(n_wrap);
    run_mode = 1'b0;
    step(5);
    chk("wrap_pulses", pulses - p0, n_wrap);
    exp_steps = (exp_steps + n_wrap) % 65536;
    chk("wrap_count", {16'd0, step_count}, {16'd0, exp_cnt()});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
